// File: rtl/alu_multicycle.sv
// alu_multicycle: EX-stage ALU with single-cycle logic/arith ops and iterative
// signed/unsigned multiply/divide writing a HI/LO register pair.
// Optional macro ALU_MC_OVF_EN adds the registered signed-overflow output ovf.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  request handshake (ready only in IDLE)
//   Control              4-bit opcode
//   in1, in2             operands (A/dividend/multiplicand, B/divisor/multiplier)
//   out_valid            one-cycle pulse when Result/Hi/Lo update
//   Result, Hi, Lo       registered result, product high/remainder, product low/quotient
//   ovf                  (ALU_MC_OVF_EN only) signed overflow, valid with out_valid
module alu_multicycle #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Control,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
`ifdef ALU_MC_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;

  logic [1:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_opb, r_hi, r_lo;
  logic [WIDTH-1:0] r_res, r_hi_o, r_lo_o;
  logic             r_valid, r_is_mul, r_neg_q, r_neg_r;

  logic             w_accept, w_is_mul, w_is_div, w_signed, w_last, w_ge;
  logic [WIDTH-1:0] w_abs1, w_abs2, w_sum, w_diff, w_sc_res, w_rsub;
  logic [WIDTH-1:0] w_q_f, w_r_f, w_fix_hi, w_fix_lo;
  logic [WIDTH:0]   w_madd, w_rsh;
  logic [2*WIDTH-1:0] w_prod_f;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_is_mul = (Control[3:1] == 3'b100);
  assign w_is_div = (Control[3:1] == 3'b101);
  assign w_signed = ~Control[0];
  assign w_last   = (r_cnt == CNT_W'(1));

  // Magnitudes for the iterative datapath; abs(MIN) wraps to the unsigned value 2^(WIDTH-1).
  assign w_abs1 = (w_signed && in1[WIDTH-1]) ? -in1 : in1;
  assign w_abs2 = (w_signed && in2[WIDTH-1]) ? -in2 : in2;

  assign w_sum  = in1 + in2;
  assign w_diff = in1 - in2;

  // Single-cycle result
  always_comb begin
    w_sc_res = '0;
    case (Control)
      OP_ADD:  w_sc_res = w_sum;
      OP_SUB:  w_sc_res = w_diff;
      OP_AND:  w_sc_res = in1 & in2;
      OP_OR:   w_sc_res = in1 | in2;
      OP_SLTU: w_sc_res = WIDTH'(in1 < in2);
      OP_SLT:  w_sc_res = WIDTH'($signed(in1) < $signed(in2));
      default: w_sc_res = '0;
    endcase
  end

  // Shift-add step: {r_hi,r_lo} holds partial product and remaining multiplier bits.
  assign w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);

  // Restoring divide step: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
  assign w_rsh  = {r_hi, r_lo[WIDTH-1]};
  assign w_ge   = (w_rsh >= {1'b0, r_opb});
  assign w_rsub = WIDTH'(w_rsh - {1'b0, r_opb});

  // Sign fix-up
  assign w_prod_f = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_q_f    = r_neg_q ? -r_lo : r_lo;
  assign w_r_f    = r_neg_r ? -r_hi : r_hi;
  assign w_fix_hi = r_is_mul ? w_prod_f[2*WIDTH-1:WIDTH] : w_r_f;
  assign w_fix_lo = r_is_mul ? w_prod_f[WIDTH-1:0]       : w_q_f;

`ifdef ALU_MC_OVF_EN
  logic r_ovf, r_mult_s, w_sc_ovf;

  always_comb begin
    w_sc_ovf = 1'b0;
    case (Control)
      OP_ADD:  w_sc_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (w_sum[WIDTH-1]  != in1[WIDTH-1]);
      OP_SUB:  w_sc_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (w_diff[WIDTH-1] != in1[WIDTH-1]);
      default: w_sc_ovf = 1'b0;
    endcase
  end

  assign ovf = r_ovf;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul)      w_state_nxt = S_MUL;
        else if (w_accept && w_is_div) w_state_nxt = S_DIV;
      end
      S_MUL, S_DIV: if (w_last) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_opb    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_res    <= '0;
      r_hi_o   <= '0;
      r_lo_o   <= '0;
      r_valid  <= 1'b0;
      r_is_mul <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
`ifdef ALU_MC_OVF_EN
      r_ovf    <= 1'b0;
      r_mult_s <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mul || w_is_div) begin
              r_opb    <= w_is_mul ? w_abs1 : w_abs2;
              r_lo     <= w_is_mul ? w_abs2 : w_abs1;
              r_hi     <= '0;
              r_is_mul <= w_is_mul;
              r_cnt    <= CNT_W'(WIDTH);
              r_neg_q  <= w_signed && (in1[WIDTH-1] ^ in2[WIDTH-1]);
              r_neg_r  <= w_signed && in1[WIDTH-1];
`ifdef ALU_MC_OVF_EN
              r_mult_s <= w_is_mul && w_signed;
`endif
            end else begin
              r_res   <= w_sc_res;
              r_valid <= 1'b1;
`ifdef ALU_MC_OVF_EN
              r_ovf   <= w_sc_ovf;
`endif
            end
          end
        end
        S_MUL: begin
          r_hi  <= w_madd[WIDTH:1];
          r_lo  <= {w_madd[0], r_lo[WIDTH-1:1]};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_DIV: begin
          r_hi  <= w_ge ? w_rsub : w_rsh[WIDTH-1:0];
          r_lo  <= {r_lo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_FIX: begin
          r_hi_o  <= w_fix_hi;
          r_lo_o  <= w_fix_lo;
          r_res   <= w_fix_lo;
          r_valid <= 1'b1;
`ifdef ALU_MC_OVF_EN
          r_ovf   <= r_mult_s && (w_fix_hi != {WIDTH{w_fix_lo[WIDTH-1]}});
`endif
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_valid;
  assign Result    = r_res;
  assign Hi        = r_hi_o;
  assign Lo        = r_lo_o;

endmodule
